// File: rtl/fpu_op_controller_if.sv
// Request, decode, core and response signal bundle for the div/sqrt
// sequencer. slave = controller side, master = environment side.
interface fpu_op_controller_if #(
    parameter int REG_SIZE = 64,
    parameter int OP_BITS  = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [REG_SIZE-1:0] in_a;
    logic [REG_SIZE-1:0] in_b;
    logic [OP_BITS-1:0]  in_op;

    logic [REG_SIZE-1:0] dec_a;
    logic [REG_SIZE-1:0] dec_b;
    logic [OP_BITS-1:0]  dec_op;
    logic                dec_sign_a;
    logic                dec_sign_b;
    logic                dec_inf_a;
    logic                dec_inf_b;
    logic                dec_zero_a;
    logic                dec_zero_b;
    logic                dec_nan_a;
    logic                dec_nan_b;

    logic                core_start;
    logic                core_done;
    logic [REG_SIZE-1:0] core_result;

    logic                out_valid;
    logic                out_ready;
    logic [REG_SIZE-1:0] out_result;
    logic [2:0]          out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        output in_ready,
        output dec_a, dec_b, dec_op,
        input  dec_sign_a, dec_sign_b, dec_inf_a, dec_inf_b,
        input  dec_zero_a, dec_zero_b, dec_nan_a, dec_nan_b,
        output core_start,
        input  core_done, core_result,
        output out_valid, out_result, out_flags,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_op,
        input  in_ready,
        input  dec_a, dec_b, dec_op,
        output dec_sign_a, dec_sign_b, dec_inf_a, dec_inf_b,
        output dec_zero_a, dec_zero_b, dec_nan_a, dec_nan_b,
        input  core_start,
        output core_done, core_result,
        input  out_valid, out_result, out_flags,
        output out_ready
    );
endinterface

// File: rtl/fpu_op_controller.sv
// Sequences one divide/sqrt at a time: decode, IEEE754 special-case
// shortcut or iterative core with timeout, then valid/ready result.
module fpu_op_controller #(
    parameter int REG_SIZE   = 64,
    parameter int OP_BITS    = 2,
    parameter int MAX_CYCLES = 128
) (
    input logic                clk,
    input logic                rst_n,
    fpu_op_controller_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_CYCLES);

    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] QNAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] INF_D  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] INF_S  = 64'h0000_0000_7F80_0000;
    localparam logic [63:0] SGN_D  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] SGN_S  = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        START,
        BUSY,
        SPECIAL,
        DONE
    } stateT;

    stateT               stateQ;
    stateT               stateD;

    logic [REG_SIZE-1:0] decA;
    logic [REG_SIZE-1:0] decB;
    logic [OP_BITS-1:0]  decOp;
    logic [REG_SIZE-1:0] spcResult;
    logic [2:0]          spcFlags;
    logic [REG_SIZE-1:0] outResult;
    logic [2:0]          outFlags;
    logic [CNT_W-1:0]    cnt;

    logic                isDiv;
    logic                isDbl;
    logic                rSign;
    logic                nanIn;
    logic                limitHit;
    logic [REG_SIZE-1:0] qnanV;
    logic [REG_SIZE-1:0] infV;
    logic [REG_SIZE-1:0] signV;
    logic                spcHit;
    logic [REG_SIZE-1:0] spcRes;
    logic [2:0]          spcFlg;

    assign bus.dec_a      = decA;
    assign bus.dec_b      = decB;
    assign bus.dec_op     = decOp;
    assign bus.out_result = outResult;
    assign bus.out_flags  = outFlags;

    assign isDiv    = ~decOp[0];
    assign isDbl    = decOp[1];
    assign rSign    = bus.dec_sign_a ^ bus.dec_sign_b;
    assign nanIn    = bus.dec_nan_a | (isDiv & bus.dec_nan_b);
    assign limitHit = (cnt == CNT_W'(MAX_CYCLES - 1));

    // Width-dependent encodings of the special results
    always_comb begin
        qnanV = isDbl ? REG_SIZE'(QNAN_D) : REG_SIZE'(QNAN_S);
        infV  = isDbl ? REG_SIZE'(INF_D)  : REG_SIZE'(INF_S);
        signV = isDbl ? REG_SIZE'(SGN_D)  : REG_SIZE'(SGN_S);
    end

    // Special-case resolution in priority order from the class flags
    always_comb begin
        spcHit = 1'b1;
        spcRes = '0;
        spcFlg = 3'b000;
        priority case (1'b1)
            nanIn: begin
                spcRes = qnanV;
                spcFlg = 3'b001;
            end
            isDiv && ((bus.dec_zero_a && bus.dec_zero_b) ||
                      (bus.dec_inf_a && bus.dec_inf_b)): begin
                spcRes = qnanV;
                spcFlg = 3'b001;
            end
            !isDiv && bus.dec_sign_a && !bus.dec_zero_a: begin
                spcRes = qnanV;
                spcFlg = 3'b001;
            end
            isDiv && bus.dec_zero_b && !bus.dec_inf_a: begin
                spcRes = infV | (rSign ? signV : '0);
                spcFlg = 3'b010;
            end
            isDiv && bus.dec_inf_a: begin
                spcRes = infV | (rSign ? signV : '0);
            end
            isDiv && (bus.dec_zero_a || bus.dec_inf_b): begin
                spcRes = rSign ? signV : '0;
            end
            !isDiv && bus.dec_zero_a: begin
                spcRes = bus.dec_sign_a ? signV : '0;
            end
            !isDiv && bus.dec_inf_a: begin
                spcRes = infV;
            end
            default: spcHit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        stateD         = stateQ;
        bus.in_ready   = 1'b0;
        bus.core_start = 1'b0;
        bus.out_valid  = 1'b0;
        case (stateQ)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    stateD = DECODE;
                end
            end
            DECODE: begin
                stateD = spcHit ? SPECIAL : START;
            end
            SPECIAL: begin
                stateD = DONE;
            end
            START: begin
                bus.core_start = 1'b1;
                stateD         = BUSY;
            end
            BUSY: begin
                if (bus.core_done || limitHit) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Operand capture, special result staging, core wait and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decA      <= '0;
            decB      <= '0;
            decOp     <= '0;
            spcResult <= '0;
            spcFlags  <= 3'b000;
            outResult <= '0;
            outFlags  <= 3'b000;
            cnt       <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (bus.in_valid) begin
                        decA  <= bus.in_a;
                        decB  <= bus.in_b;
                        decOp <= bus.in_op;
                    end
                end
                DECODE: begin
                    spcResult <= spcRes;
                    spcFlags  <= spcFlg;
                end
                SPECIAL: begin
                    outResult <= spcResult;
                    outFlags  <= spcFlags;
                end
                START: begin
                    cnt <= '0;
                end
                BUSY: begin
                    if (bus.core_done) begin
                        outResult <= bus.core_result;
                        outFlags  <= 3'b000;
                    end else if (limitHit) begin
                        outResult <= qnanV;
                        outFlags  <= 3'b100;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_op_controller.sv
// Directed and random transactions for the div/sqrt sequencer against a
// classification-based IEEE754 reference and a simple core model.
module tb_fpu_op_controller;
    localparam int MAXC = 16;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFail;

    fpu_op_controller_if #(.REG_SIZE(64), .OP_BITS(2)) bus ();

    fpu_op_controller #(
        .REG_SIZE(64),
        .OP_BITS(2),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sign, inf, zero, nan} from the IEEE754 field layout
    function automatic logic [3:0] cls(input logic [63:0] v, input logic dbl);
        logic [63:0] e;
        logic [63:0] m;
        logic [63:0] emax;
        logic        s;
        if (dbl) begin
            s    = v[63];
            e    = (v >> 52) & 64'h7FF;
            m    = v & ((64'd1 << 52) - 64'd1);
            emax = 64'd2047;
        end else begin
            s    = v[31];
            e    = (v >> 23) & 64'hFF;
            m    = v & 64'h7F_FFFF;
            emax = 64'd255;
        end
        return {s, (e == emax) && (m == 0), (e == 0) && (m == 0),
                (e == emax) && (m != 0)};
    endfunction

    // Decode-stage model feeding the class flags back
    always_comb begin
        logic [3:0] ca;
        logic [3:0] cb;
        ca = cls(bus.dec_a, bus.dec_op[1]);
        cb = cls(bus.dec_b, bus.dec_op[1]);
        {bus.dec_sign_a, bus.dec_inf_a, bus.dec_zero_a, bus.dec_nan_a} = ca;
        {bus.dec_sign_b, bus.dec_inf_b, bus.dec_zero_b, bus.dec_nan_b} = cb;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // IEEE754 special-case rules applied to raw operands
    task automatic refModel(input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, output bit hit,
                            output logic [63:0] res, output logic [2:0] flg);
        logic       dbl;
        logic       div;
        logic [3:0] ca;
        logic [3:0] cb;
        logic       sa, ia, za, na, sb, ib, zb, nb, s;
        logic [63:0] qn;
        logic [63:0] inf;
        logic [63:0] sg;
        dbl = op[1];
        div = !op[0];
        ca  = cls(a, dbl);
        cb  = cls(b, dbl);
        {sa, ia, za, na} = ca;
        {sb, ib, zb, nb} = cb;
        s   = sa ^ sb;
        qn  = dbl ? 64'h7FF8000000000000 : 64'h7FC00000;
        inf = dbl ? 64'h7FF0000000000000 : 64'h7F800000;
        sg  = dbl ? 64'h8000000000000000 : 64'h80000000;
        hit = 1'b1;
        res = 64'd0;
        flg = 3'b000;
        if (na || (div && nb)) begin
            res = qn; flg = 3'b001;
        end else if (div && ((za && zb) || (ia && ib))) begin
            res = qn; flg = 3'b001;
        end else if (!div && sa && !za) begin
            res = qn; flg = 3'b001;
        end else if (div && zb && !za && !ia) begin
            res = inf | (s ? sg : 64'd0); flg = 3'b010;
        end else if (div && ia) begin
            res = inf | (s ? sg : 64'd0);
        end else if (div && (za || ib)) begin
            res = s ? sg : 64'd0;
        end else if (!div && za) begin
            res = sa ? sg : 64'd0;
        end else if (!div && ia) begin
            res = inf;
        end else begin
            hit = 1'b0;
        end
    endtask

    task automatic runTxn(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] op,
                          input int delay, input logic [63:0] coreVal,
                          input int hold);
        bit          hit;
        logic [63:0] eRes;
        logic [2:0]  eFlg;
        int          eLat;
        int          eStarts;
        int          cyc;
        int          startCyc;
        int          starts;
        int          lat;
        refModel(a, b, op, hit, eRes, eFlg);
        if (hit) begin
            eLat    = 3;
            eStarts = 0;
        end else begin
            eStarts = 1;
            if (delay <= MAXC) begin
                eRes = coreVal;
                eFlg = 3'b000;
                eLat = 3 + delay;
            end else begin
                eRes = op[1] ? 64'h7FF8000000000000 : 64'h7FC00000;
                eFlg = 3'b100;
                eLat = 3 + MAXC;
            end
        end
        chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = {$urandom, $urandom};
        bus.in_b     = {$urandom, $urandom};
        cyc      = 1;
        startCyc = -1;
        starts   = 0;
        lat      = -1;
        while (lat < 0 && cyc < MAXC + 60) begin
            if (bus.core_start) begin
                starts++;
                if (startCyc < 0) startCyc = cyc;
            end
            if (bus.out_valid) begin
                lat = cyc;
            end else begin
                bus.core_done   = (startCyc >= 0) && (cyc == startCyc + delay);
                bus.core_result = bus.core_done ? coreVal : {$urandom, $urandom};
                @(negedge clk);
                cyc++;
            end
        end
        bus.core_done = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'(eLat));
        chk({tag, "/starts"}, 64'(starts), 64'(eStarts));
        chk({tag, "/result"}, bus.out_result, eRes);
        chk({tag, "/flags"}, 64'(bus.out_flags), 64'(eFlg));
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            bus.core_done = 1'b1;
            @(negedge clk);
            chk({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "/hold_result"}, bus.out_result, eRes);
            chk({tag, "/hold_flags"}, 64'(bus.out_flags), 64'(eFlg));
            chk({tag, "/hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.core_done = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "/post_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/post_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    function automatic logic [63:0] pickOp(input logic dbl);
        int          k;
        logic [63:0] sg;
        logic [63:0] e;
        logic [63:0] m;
        logic [63:0] v;
        k  = $urandom_range(0, 7);
        sg = dbl ? 64'h8000000000000000 : 64'h80000000;
        if (dbl) begin
            m = {$urandom, $urandom} & ((64'd1 << 52) - 64'd1);
            e = 64'($urandom_range(1, 2046));
        end else begin
            m = 64'($urandom) & 64'h7F_FFFF;
            e = 64'($urandom_range(1, 254));
        end
        if (m == 0) m = 64'd1;
        case (k)
            0: v = 64'd0;
            1: v = dbl ? 64'h7FF0000000000000 : 64'h7F800000;
            2: v = (dbl ? 64'h7FF0000000000000 : 64'h7F800000) | m;
            3: v = m;
            default: v = dbl ? ((e << 52) | m) : ((e << 23) | m);
        endcase
        if ($urandom_range(0, 1) == 1) v = v | sg;
        return v;
    endfunction

    initial begin
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        nChecks         = 0;
        nFail           = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_op       = '0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        bus.out_ready   = 1'b0;
        #12;
        chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst/core_start", 64'(bus.core_start), 64'd0);
        chk("rst/dec_a", bus.dec_a, 64'd0);
        chk("rst/dec_op", 64'(bus.dec_op), 64'd0);
        chk("rst/out_result", bus.out_result, 64'd0);
        chk("rst/out_flags", 64'(bus.out_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runTxn("div6by2", 64'h40C00000, 64'h40000000, 2'b00, 10,
               64'h40400000, 0);
        runTxn("div1by0", 64'h3F800000, 64'h00000000, 2'b00, 10,
               64'h12345678, 0);
        runTxn("sqrtNeg", 64'hC0800000, 64'h7FC00000, 2'b01, 10,
               64'h12345678, 0);
        runTxn("sqrtNegZero", 64'h8000000000000000, 64'd0, 2'b11, 10,
               64'h12345678, 0);
        runTxn("timeout", 64'h4000000000000000, 64'h3FF0000000000000,
               2'b10, 1000, 64'h1, 0);
        for (int i = 0; i < 3; i++) begin
            bus.core_done = 1'b1;
            @(negedge clk);
            chk("late_done/in_ready", 64'(bus.in_ready), 64'd1);
            chk("late_done/out_valid", 64'(bus.out_valid), 64'd0);
            chk("late_done/core_start", 64'(bus.core_start), 64'd0);
        end
        bus.core_done = 1'b0;
        runTxn("doneAtLimit", 64'h40000000, 64'h40400000, 2'b00, MAXC,
               64'hABCD, 0);
        runTxn("limitPlus1", 64'h40000000, 64'h40400000, 2'b00, MAXC + 1,
               64'hABCD, 0);
        runTxn("holdReady", 64'h40000000, 64'h40400000, 2'b00, 4,
               64'h3F2AAAAB, 5);

        bus.in_a     = 64'h40000000;
        bus.in_b     = 64'h3F800000;
        bus.in_op    = 2'b00;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy/in_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst/in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst/core_start", 64'(bus.core_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runTxn("afterReset", 64'h40C00000, 64'h40000000, 2'b00, 7,
               64'h40400000, 1);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pickOp(op[1]);
            b  = pickOp(op[1]);
            runTxn($sformatf("rnd%0d", i), a, b, op,
                   $urandom_range(1, MAXC + 3), {$urandom, $urandom},
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end
endmodule
